mult_seq_shift_add: RTL and testbench
=====================================

Name: mult_seq_shift_add

Overview:
- Parametrised sequential shift-and-add multiplier, next generation of the 4-bit multiplier datapath (accumulator plus add-b stage).
- Width is set by a parameter. Adds a start/busy/done handshake, a per-operation signed mode and a held result register.
- Sits between operand registers and the result bus. One partial-product step per clock.

Parameters:
- N, 4, operand width in bits; legal range 2..16.
- CW, $clog2(N+1), step-counter width; derived, never overridden.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_b  input  1  reset; asynchronous, active-low.
- start  input  1  request a new multiplication; sampled only in IDLE.
- sgn  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- a  input  N  multiplicand; sampled with start.
- b  input  N  multiplier; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when p is updated.
- p  output  2N  product; holds its value until the next done.

Behaviour:
- Reset (rst_b=0, asynchronous): state=IDLE, busy=0, done=0, p=0, internal acc/Q/M/cnt=0. Released synchronously to clk by the system.
- Registers:
  - M: N bits, magnitude of a.
  - Q: N bits, magnitude of b, shifted right each step.
  - acc: N+1 bits.
  - cnt: CW bits.
  - neg: 1 bit, result-sign flag.
- FSM states: IDLE, RUN.
- IDLE, start=1 at a clock edge:
  - If sgn=1: M=|a|, Q=|b|, neg=a[N-1]^b[N-1].
  - If sgn=0: M=a, Q=b, neg=0.
  - acc=0, cnt=0, busy=1, go to RUN.
  - |-2^(N-1)| = 2^(N-1) fits in N unsigned bits; no overflow.
- RUN, each edge:
  - sum = Q[0] ? acc[N-1:0]+M : acc[N-1:0], computed (N+1)-bit wide.
  - {acc,Q} = {sum,Q} >> 1, logical shift; the top bit comes from the sum carry.
  - cnt = cnt+1.
- RUN, on the edge where cnt==N-1 (the N-th step):
  - p = neg ? -({acc,Q}_next[2N-1:0]) : {acc,Q}_next[2N-1:0], two's-complement negation in 2N bits.
  - done=1, busy=0, go to IDLE.
- done is high for exactly one cycle, then returns to 0.
- Latency: start sampled at edge k, p/done valid after edge k+N. busy is high after edges k..k+N-1.
- start while busy=1: ignored. Operands and sgn are not re-sampled; the operation in flight is unaffected.
- start high in the cycle done=1: state is IDLE, so it is accepted. Back-to-back throughput is one result per N+1 cycles.
- start held high continuously: a new operation begins on every IDLE edge.
- a/b/sgn changing during RUN: no effect.
- Reset asserted mid-operation: immediate return to IDLE. busy=0, done=0, p=0, partial result discarded, no done pulse.
- Unsigned result range: 0..(2^N-1)^2, always fits in 2N bits.
- Signed result range: -2^(N-1)*(2^(N-1)-1) .. 2^(2N-2), fits in 2N-bit two's complement.
- Zero operand: p=0; neg is irrelevant because -0=0.

Test Plan:
- N=4, sgn=0, a=4'b1101 (13), b=4'b0110 (6), start pulse -> busy high 4 cycles, done pulse after 4th step, p=8'd78 (8'h4E); p held afterwards.
- N=4, sgn=0, a=15, b=15 -> p=8'hE1 (225). Then a=0, b=9 -> p=8'h00.
- N=4, sgn=1: a=4'b1000 (-8), b=4'b1000 (-8) -> p=8'h40 (64). a=4'b1101 (-3), b=4'b0101 (5) -> p=8'hF1 (-15).
- Start 13*6, pulse start again with a=2, b=2 at cycle 2 of RUN -> ignored, p=78. Then assert start in the done cycle with 2*2 -> accepted, next done gives p=8'h04.
- Start 15*15, drop rst_b after 2 RUN cycles -> busy, done and p go to 0 immediately, no done pulse. After release, 3*3 -> p=8'h09.
- N=8 instance, sgn=0, a=255, b=255 -> done after 8 steps, p=16'hFE01. sgn=1, a=-128, b=127 -> p=16'hC080 (-16256).

Source files
------------

// File: rtl/mult_seq_shift_add.sv
// mult_seq_shift_add: sequential shift-and-add multiplier.
//
// Computes p = a * b, one partial-product step per clock. The operation
// takes N steps. Signed operands are handled by multiplying their
// magnitudes and negating the product at the end.
//
// Ports
//   clk    in   1    system clock, rising edge active
//   rst_b  in   1    asynchronous active-low reset
//   start  in   1    request a new multiplication (sampled only in IDLE)
//   sgn    in   1    1 = two's-complement operands, 0 = unsigned
//   a      in   N    multiplicand
//   b      in   N    multiplier
//   busy   out  1    high while an operation is in progress
//   done   out  1    one-cycle pulse when p is updated
//   p      out  2N   product, held until the next done
//
// Parameters
//   N      operand width, 2..16
//   CW     step-counter width, derived from N (leave at default)

module mult_seq_shift_add #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic           start,
  input  logic           sgn,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
  localparam logic [2*N-1:0] P_ONE    = {{(2*N-1){1'b0}}, 1'b1};

  // Two's-complement magnitude. The most negative value maps to 2^(N-1),
  // which still fits in N unsigned bits.
  function automatic logic [N-1:0] magnitude(input logic [N-1:0] v);
    logic [N-1:0] r;
    if (v[N-1]) begin
      r = ~v + {{(N-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t         state_r, state_nxt_s;
  logic [N:0]     acc_r,   acc_nxt_s;
  logic [N-1:0]   m_r,     m_nxt_s;
  logic [N-1:0]   q_r,     q_nxt_s;
  logic [CW-1:0]  cnt_r,   cnt_nxt_s;
  logic           neg_r,   neg_nxt_s;
  logic           busy_r,  busy_nxt_s;
  logic           done_r,  done_nxt_s;
  logic [2*N-1:0] p_r,     p_nxt_s;

  logic [N:0]     sum_s;
  logic [2*N-1:0] prod_s;

  // Partial-product add and the product word the final step would produce.
  always_comb begin
    // acc_r[N] is always zero after a shift, so adding the full acc_r is
    // the same as adding acc_r[N-1:0] zero-extended.
    if (q_r[0]) begin
      sum_s = acc_r + {1'b0, m_r};
    end else begin
      sum_s = acc_r;
    end
    // Low 2N bits of {sum, Q} >> 1.
    prod_s = {sum_s, q_r[N-1:1]};
  end

  // Next-state and datapath update; everything holds unless changed below.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    m_nxt_s     = m_r;
    q_nxt_s     = q_r;
    cnt_nxt_s   = cnt_r;
    neg_nxt_s   = neg_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    p_nxt_s     = p_r;

    case (state_r)
      IDLE: begin
        if (start) begin
          if (sgn) begin
            m_nxt_s   = magnitude(a);
            q_nxt_s   = magnitude(b);
            neg_nxt_s = a[N-1] ^ b[N-1];
          end else begin
            m_nxt_s   = a;
            q_nxt_s   = b;
            neg_nxt_s = 1'b0;
          end
          acc_nxt_s   = '0;
          cnt_nxt_s   = '0;
          busy_nxt_s  = 1'b1;
          state_nxt_s = RUN;
        end else begin
          busy_nxt_s  = 1'b0;
        end
      end

      RUN: begin
        // {acc,Q} = {sum,Q} >> 1; the carry of sum becomes acc's new MSB-1.
        acc_nxt_s = {1'b0, sum_s[N:1]};
        q_nxt_s   = {sum_s[0], q_r[N-1:1]};
        cnt_nxt_s = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          if (neg_r) begin
            p_nxt_s = ~prod_s + P_ONE;
          end else begin
            p_nxt_s = prod_s;
          end
          done_nxt_s  = 1'b1;
          busy_nxt_s  = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          busy_nxt_s  = 1'b1;
        end
      end

      default: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset discards any operation.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= IDLE;
      acc_r   <= '0;
      m_r     <= '0;
      q_r     <= '0;
      cnt_r   <= '0;
      neg_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      p_r     <= '0;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      m_r     <= m_nxt_s;
      q_r     <= q_nxt_s;
      cnt_r   <= cnt_nxt_s;
      neg_r   <= neg_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      p_r     <= p_nxt_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign p    = p_r;

  mult_seq_shift_add_chk #(.N(N)) u_chk (
    .clk   (clk),
    .rst_b (rst_b),
    .busy  (busy_r),
    .done  (done_r),
    .p     (p_r)
  );

endmodule

// mult_seq_shift_add_chk: protocol properties of the multiplier outputs.
//
// Ports (all inputs): clk, rst_b, busy, done, p (2N bits).
module mult_seq_shift_add_chk #(
  parameter int N = 4
) (
  input logic           clk,
  input logic           rst_b,
  input logic           busy,
  input logic           done,
  input logic [2*N-1:0] p
);

  // done never lasts more than one cycle.
  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_b)
    done |=> !done);

  // The result is only reported once the operation has finished.
  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_b)
    !(busy && done));

  // p only changes together with a done pulse.
  a_p_held: assert property (@(posedge clk) disable iff (!rst_b)
    (p != $past(p)) |-> done);

endmodule

// File: tb/tb_mult_seq_shift_add.sv
// Bench for mult_seq_shift_add: directed vectors on an N=4 and an N=8
// instance. Stimulus pushes expected products into per-instance queues;
// monitors pop and compare on every done pulse and check p is held between.
module tb_mult_seq_shift_add;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b;
  logic        start4, sgn4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        start8, sgn8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int total = 0;
  int bad   = 0;

  logic [7:0]  q4[$];
  logic [15:0] q8[$];
  logic [7:0]  hold4, e4;
  logic [15:0] hold8, e8;

  mult_seq_shift_add #(.N(4)) dut4 (
    .clk(clk), .rst_b(rst_b), .start(start4), .sgn(sgn4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .p(p4)
  );

  mult_seq_shift_add #(.N(8)) dut8 (
    .clk(clk), .rst_b(rst_b), .start(start8), .sgn(sgn8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // N=4 monitor: compare on done, otherwise p must hold the last result.
  always @(negedge clk) begin
    if (!rst_b) begin
      hold4 = 8'h00;
    end else if (done4) begin
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done4_unexpected: got done with p=%0h, required no done", p4);
      end else begin
        e4 = q4.pop_front();
        check("p4", {24'd0, p4}, {24'd0, e4});
        hold4 = e4;
      end
    end else begin
      check("p4_hold", {24'd0, p4}, {24'd0, hold4});
    end
  end

  // N=8 monitor.
  always @(negedge clk) begin
    if (!rst_b) begin
      hold8 = 16'h0000;
    end else if (done8) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done8_unexpected: got done with p=%0h, required no done", p8);
      end else begin
        e8 = q8.pop_front();
        check("p8", {16'd0, p8}, {16'd0, e8});
        hold8 = e8;
      end
    end else begin
      check("p8_hold", {16'd0, p8}, {16'd0, hold8});
    end
  end

  // Drive one start pulse (called at a negedge); optionally expect a result.
  task automatic issue(input bit w8, input bit s, input logic [7:0] av,
                       input logic [7:0] bv, input logic [15:0] exp,
                       input bit push);
    if (w8) begin
      start8 = 1'b1; sgn8 = s; a8 = av; b8 = bv;
      if (push) q8.push_back(exp);
    end else begin
      start4 = 1'b1; sgn4 = s; a4 = av[3:0]; b4 = bv[3:0];
      if (push) q4.push_back(exp[7:0]);
    end
  endtask

  // Wait for done (bounded), counting cycles seen with busy high.
  task automatic wait_done(input bit w8, input int exp_busy, input string name);
    int nb;
    bit got;
    nb  = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      start4 = 1'b0;
      start8 = 1'b0;
      if (w8 ? done8 : done4) got = 1'b1;
      else if (w8 ? busy8 : busy4) nb++;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done in 40 cycles, required done", name);
    end else begin
      check({name, "_busy"}, nb, exp_busy);
    end
  endtask

  initial begin
    rst_b  = 1'b0;
    start4 = 1'b0; sgn4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    start8 = 1'b0; sgn8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy4", {31'd0, busy4}, 32'd0);
    check("rst_done4", {31'd0, done4}, 32'd0);
    check("rst_p4",    {24'd0, p4},    32'd0);
    check("rst_busy8", {31'd0, busy8}, 32'd0);
    check("rst_done8", {31'd0, done8}, 32'd0);
    check("rst_p8",    {16'd0, p8},    32'd0);
    rst_b = 1'b1;

    // Unsigned N=4.
    @(negedge clk); issue(1'b0, 1'b0, 8'd13, 8'd6, 16'h004E, 1'b1);
    wait_done(1'b0, 4, "u13x6");
    repeat (3) @(negedge clk);
    check("p4_held_78", {24'd0, p4}, 32'h4E);
    @(negedge clk); issue(1'b0, 1'b0, 8'd15, 8'd15, 16'h00E1, 1'b1);
    wait_done(1'b0, 4, "u15x15");
    @(negedge clk); issue(1'b0, 1'b0, 8'd0, 8'd9, 16'h0000, 1'b1);
    wait_done(1'b0, 4, "u0x9");

    // Signed N=4.
    @(negedge clk); issue(1'b0, 1'b1, 8'h08, 8'h08, 16'h0040, 1'b1);
    wait_done(1'b0, 4, "sm8xm8");
    @(negedge clk); issue(1'b0, 1'b1, 8'h0D, 8'h05, 16'h00F1, 1'b1);
    wait_done(1'b0, 4, "sm3x5");

    // Start during RUN is ignored; start in the done cycle is accepted.
    @(negedge clk); issue(1'b0, 1'b0, 8'd13, 8'd6, 16'h004E, 1'b1);
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); issue(1'b0, 1'b0, 8'd2, 8'd2, 16'h0000, 1'b0);
    wait_done(1'b0, 2, "ignored");
    issue(1'b0, 1'b0, 8'd2, 8'd2, 16'h0004, 1'b1);
    wait_done(1'b0, 4, "done_cycle");

    // Reset mid-operation.
    @(negedge clk); issue(1'b0, 1'b0, 8'd15, 8'd15, 16'h0000, 1'b0);
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); rst_b = 1'b0;
    #1;
    check("midrst_busy4", {31'd0, busy4}, 32'd0);
    check("midrst_done4", {31'd0, done4}, 32'd0);
    check("midrst_p4",    {24'd0, p4},    32'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check("postrst_busy4", {31'd0, busy4}, 32'd0);
    check("postrst_p4",    {24'd0, p4},    32'd0);
    issue(1'b0, 1'b0, 8'd3, 8'd3, 16'h0009, 1'b1);
    wait_done(1'b0, 4, "u3x3");

    // N=8 instance.
    @(negedge clk); issue(1'b1, 1'b0, 8'd255, 8'd255, 16'hFE01, 1'b1);
    wait_done(1'b1, 8, "u255x255");
    @(negedge clk); issue(1'b1, 1'b1, 8'h80, 8'h7F, 16'hC080, 1'b1);
    wait_done(1'b1, 8, "sm128x127");

    repeat (3) @(negedge clk);
    check("q4_drained", q4.size(), 32'd0);
    check("q8_drained", q8.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
